// File: rtl/axis_averager_sequencer.sv
// Run controller ahead of the complex averager: frame-aligned start,
// stream gating, averaged-frame counting and run status.
module axis_averager_sequencer #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int COUNT_WIDTH      = 16
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        cfg_start,
  input  logic                        cfg_abort,
  input  logic                        cfg_continuous,
  input  logic [4:0]                  cfg_log_count,
  input  logic [COUNT_WIDTH-1:0]      cfg_num_results,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        S_AXIS_tvalid,
  input  logic                        S_AXIS_tlast,
  output logic                        S_AXIS_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready,
  output logic                        avg_aresetn,
  output logic [4:0]                  avg_log_count,
  input  logic                        mon_tvalid,
  input  logic                        mon_tready,
  input  logic                        mon_tlast,
  output logic                        busy,
  output logic                        done,
  output logic                        overrun,
  output logic [COUNT_WIDTH-1:0]      result_count
);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    RUN,
    DONE
  } state_e;

  state_e                 state_q, state_d;
  logic                   avg_aresetn_q, avg_aresetn_d;
  logic [4:0]             log_count_q, log_count_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   overrun_q, overrun_d;
  logic                   cont_q, cont_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] num_q, num_d;
  logic [COUNT_WIDTH-1:0] count_inc;
  logic                   mon_last;

  assign mon_last  = mon_tvalid & mon_tready & mon_tlast;
  assign count_inc = count_q + COUNT_WIDTH'(1);

  assign M_AXIS_tdata  = S_AXIS_tdata;
  assign avg_aresetn   = avg_aresetn_q;
  assign avg_log_count = log_count_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign overrun       = overrun_q;
  assign result_count  = count_q;

  // Outside RUN the upstream is drained so frame alignment keeps moving.
  always_comb begin
    S_AXIS_tready = 1'b1;
    M_AXIS_tvalid = 1'b0;
    if (state_q == RUN) begin
      S_AXIS_tready = M_AXIS_tready;
      M_AXIS_tvalid = S_AXIS_tvalid;
    end
  end

  always_comb begin
    state_d       = state_q;
    avg_aresetn_d = avg_aresetn_q;
    log_count_d   = log_count_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    overrun_d     = overrun_q;
    cont_d        = cont_q;
    count_d       = count_q;
    num_d         = num_q;
    case (state_q)
      IDLE: begin
        if (cfg_start && !cfg_abort) begin
          state_d       = ARM;
          avg_aresetn_d = 1'b1;
          log_count_d   = cfg_log_count;
          busy_d        = 1'b1;
          overrun_d     = 1'b0;
          cont_d        = cfg_continuous;
          count_d       = '0;
          num_d         = (cfg_num_results == '0) ?
                          COUNT_WIDTH'(1) : cfg_num_results;
        end
      end
      ARM: begin
        if (cfg_abort) begin
          state_d       = IDLE;
          avg_aresetn_d = 1'b0;
          busy_d        = 1'b0;
        end else if (S_AXIS_tvalid && S_AXIS_tlast) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (S_AXIS_tvalid && !M_AXIS_tready) begin
          overrun_d = 1'b1;
        end
        if (mon_last) begin
          count_d = count_inc;
        end
        if (cfg_abort) begin
          state_d       = IDLE;
          avg_aresetn_d = 1'b0;
          busy_d        = 1'b0;
        end else if (mon_last && !cont_q && count_inc == num_q) begin
          state_d       = DONE;
          avg_aresetn_d = 1'b0;
          busy_d        = 1'b0;
          done_d        = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      avg_aresetn_q <= 1'b0;
      log_count_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      overrun_q     <= 1'b0;
      cont_q        <= 1'b0;
      count_q       <= '0;
      num_q         <= COUNT_WIDTH'(1);
    end else begin
      state_q       <= state_d;
      avg_aresetn_q <= avg_aresetn_d;
      log_count_q   <= log_count_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      overrun_q     <= overrun_d;
      cont_q        <= cont_d;
      count_q       <= count_d;
      num_q         <= num_d;
    end
  end

endmodule
